// File: rtl/fir_pkg.sv
// Shared types and derived constants for the FIR MAC sequencer.
package fir_pkg;
  localparam int unsigned H_ADDR_WIDTH = 4;
  localparam int unsigned X_ADDR_WIDTH = 6;
  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned MEM_LAT      = 1;
  localparam int unsigned DSP_LAT      = 4;
  localparam int unsigned L            = 1 << H_ADDR_WIDTH;
  localparam int unsigned X_DEPTH      = 1 << X_ADDR_WIDTH;
  localparam int unsigned NUM_OUT      = X_DEPTH - L + 1;
  localparam int unsigned PIPE_DEPTH   = MEM_LAT + DSP_LAT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;
endpackage

// File: rtl/fir_tag_pipe.sv
// Shift register of per-tap tags; stage i holds the tag i cycles after its memory read.
module fir_tag_pipe
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH   = PIPE_DEPTH + 1,
  parameter int unsigned CE_TAP  = MEM_LAT - 1,
  parameter int unsigned PRE_TAP = PIPE_DEPTH - 1
) (
  input  logic clk,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t ce_tap,
  output tag_t pre_tap,
  output tag_t out_tap
);
  tag_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) stages[i] <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) stages[i] <= stages[i-1];
    end
  end

  assign ce_tap  = stages[CE_TAP];
  assign pre_tap = stages[PRE_TAP];
  assign out_tap = stages[DEPTH-1];
endmodule

// File: rtl/fir_mac_sequencer.sv
// Run-time controller for the single-DSP FIR: issues H/X addresses, steers the
// accumulator, captures finished outputs and accumulates sticky exception flags.
module fir_mac_sequencer
  import fir_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    rd_en_o,
  output logic [H_ADDR_WIDTH-1:0] h_addr_o,
  output logic [X_ADDR_WIDTH-1:0] x_addr_o,
  output logic                    dsp_ce_o,
  output logic                    fpopmode_bit_o,
  input  logic [DATA_WIDTH-1:0]   y_i,
  input  logic                    invalid_i,
  input  logic                    overflow_i,
  input  logic                    underflow_i,
  output logic                    y_we_o,
  output logic [X_ADDR_WIDTH-1:0] y_addr_o,
  output logic [DATA_WIDTH-1:0]   y_data_o,
  output logic [2:0]              err_o
);
  state_t                  state;
  logic [H_ADDR_WIDTH-1:0] k;
  logic [X_ADDR_WIDTH-1:0] n;
  logic [X_ADDR_WIDTH-1:0] wr_n;
  tag_t                    tag_in, ce_tap, pre_tap, out_tap;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = (state == ISSUE);
    tag_in.first = (state == ISSUE) && (k == '0);
    tag_in.last  = (state == ISSUE) && (k == H_ADDR_WIDTH'(L - 1));
  end

  fir_tag_pipe u_tag_pipe (
    .clk     (clk),
    .flush   (rst_i | abort_i),
    .tag_in  (tag_in),
    .ce_tap  (ce_tap),
    .pre_tap (pre_tap),
    .out_tap (out_tap)
  );

  // Non-final outputs restart one cycle early so the next tap 0 lands right
  // behind the retiring last tap, giving an exact L+MEM_LAT+DSP_LAT period.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state          <= IDLE;
      k              <= '0;
      n              <= '0;
      wr_n           <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      rd_en_o        <= 1'b0;
      h_addr_o       <= '0;
      x_addr_o       <= '0;
      dsp_ce_o       <= 1'b0;
      fpopmode_bit_o <= 1'b0;
      y_we_o         <= 1'b0;
      y_addr_o       <= '0;
      y_data_o       <= '0;
      err_o          <= '0;
    end else if (abort_i) begin
      state          <= IDLE;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      rd_en_o        <= 1'b0;
      dsp_ce_o       <= 1'b0;
      fpopmode_bit_o <= 1'b0;
      y_we_o         <= 1'b0;
    end else begin
      done_o         <= 1'b0;
      rd_en_o        <= 1'b0;
      y_we_o         <= 1'b0;
      dsp_ce_o       <= ce_tap.valid;
      fpopmode_bit_o <= ce_tap.valid & ~ce_tap.first;
      if (out_tap.valid) err_o <= err_o | {invalid_i, overflow_i, underflow_i};
      if (out_tap.valid && out_tap.last) begin
        y_we_o   <= 1'b1;
        y_addr_o <= wr_n;
        y_data_o <= y_i;
        wr_n     <= wr_n + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= ISSUE;
            n      <= '0;
            k      <= '0;
            wr_n   <= '0;
            err_o  <= '0;
            busy_o <= 1'b1;
          end
        end
        ISSUE: begin
          rd_en_o  <= 1'b1;
          h_addr_o <= k;
          x_addr_o <= n + X_ADDR_WIDTH'(k);
          k        <= k + 1'b1;
          if (k == H_ADDR_WIDTH'(L - 1)) state <= DRAIN;
        end
        DRAIN: begin
          if (n == X_ADDR_WIDTH'(NUM_OUT - 1)) begin
            if (out_tap.valid && out_tap.last) state <= DONE;
          end else if (pre_tap.valid && pre_tap.last) begin
            n     <= n + 1'b1;
            k     <= '0;
            state <= ISSUE;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a behavioural memory/DSP model and
// a queue of expected result-buffer writes.
module tb_fir_mac_sequencer;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
  logic        busy_o, done_o, rd_en_o, dsp_ce_o, fpopmode_bit_o, y_we_o;
  logic [3:0]  h_addr_o;
  logic [5:0]  x_addr_o, y_addr_o;
  logic [31:0] y_i, y_data_o;
  logic        invalid_i = 1'b0, overflow_i = 1'b0, underflow_i = 1'b0;
  logic [2:0]  err_o;

  fir_mac_sequencer dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
    .h_addr_o(h_addr_o), .x_addr_o(x_addr_o), .dsp_ce_o(dsp_ce_o),
    .fpopmode_bit_o(fpopmode_bit_o), .y_i(y_i), .invalid_i(invalid_i),
    .overflow_i(overflow_i), .underflow_i(underflow_i), .y_we_o(y_we_o),
    .y_addr_o(y_addr_o), .y_data_o(y_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] int_to_f32(input int unsigned v);
    int          e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (v[i]) e = i;
    m = v << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Memory (h[k]=1, x[i]=i, one-cycle read) feeding a DSP whose y is valid 4 cycles after its CE.
  int   hd = 0, xd = 0, acc = 0, acc_n;
  int   ysr [4];
  logic [3:0] vsr = '0;
  logic out_valid;
  assign acc_n     = fpopmode_bit_o ? acc + hd * xd : hd * xd;
  assign out_valid = vsr[3];
  assign y_i       = int_to_f32(int'(ysr[3]));
  always @(posedge clk) begin
    if (rd_en_o) begin
      hd <= 1;
      xd <= int'(x_addr_o);
    end
    if (dsp_ce_o) acc <= acc_n;
    ysr[0] <= acc_n;
    ysr[1] <= ysr[0];
    ysr[2] <= ysr[1];
    ysr[3] <= ysr[2];
    vsr    <= {vsr[2:0], dsp_ce_o};
  end

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb [$];
  int   tests = 0, fails = 0;
  int   last_we = 0;
  bit   have_last = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_run();
    sb.delete();
    have_last = 0;
    for (int n = 0; n < 49; n++) sb.push_back('{n, int_to_f32(32'(16 * n + 120))});
  endtask

  task automatic wait_write();
    int   t = 0;
    exp_t e;
    do begin
      @(negedge clk);
      t++;
    end while (!y_we_o && t < 60);
    if (!y_we_o) begin
      check("write_timeout", 64'(y_we_o), 64'd1);
    end else if (sb.size() == 0) begin
      check("unexpected_write", 64'(y_we_o), 64'd0);
    end else begin
      e = sb.pop_front();
      check("y_addr", 64'(y_addr_o), 64'(e.addr));
      check("y_data", 64'(y_data_o), 64'(e.data));
      if (have_last) check("we_spacing", 64'(cyc - last_we), 64'd21);
      last_we   = cyc;
      have_last = 1;
    end
  endtask

  task automatic idle_watch(input int c, input string tag);
    int we = 0, dn = 0;
    repeat (c) begin
      @(negedge clk);
      if (y_we_o) we++;
      if (done_o) dn++;
    end
    check({tag, "_no_write"}, 64'(we), 64'd0);
    check({tag, "_no_done"}, 64'(dn), 64'd0);
  endtask

  task automatic inject_overflow(input string tag);
    int t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid_seen"}, 64'(out_valid), 64'd1);
    overflow_i = 1'b1;
    @(negedge clk);
    overflow_i = 1'b0;
    check({tag, "_err"}, 64'(err_o), 64'b010);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    check("rst_busy", 64'(busy_o), 0);
    check("rst_done", 64'(done_o), 0);
    check("rst_rd_en", 64'(rd_en_o), 0);
    check("rst_err", 64'(err_o), 0);
    check("rst_y_we", 64'(y_we_o), 0);

    // Run 1: address sequence, opmode timing, full run, start-while-busy, sticky overflow
    push_run();
    pulse_start();
    check("busy_rise", 64'(busy_o), 1);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16) begin
        check("rd_en", 64'(rd_en_o), 1);
        check("h_addr", 64'(h_addr_o), 64'(i));
        check("x_addr", 64'(x_addr_o), 64'(i));
      end else begin
        check("rd_en_drain", 64'(rd_en_o), 0);
      end
      check("dsp_ce", 64'(dsp_ce_o), 64'(i >= 1));
      check("fpopmode", 64'(fpopmode_bit_o), 64'(i >= 2));
    end
    inject_overflow("run1");
    for (int w = 0; w < 49; w++) begin
      wait_write();
      if (w == 2) pulse_start();
    end
    check("writes_left", 64'(sb.size()), 0);
    @(negedge clk);
    check("done_pulse", 64'(done_o), 1);
    check("busy_at_done", 64'(busy_o), 0);
    @(negedge clk);
    check("done_one_cycle", 64'(done_o), 0);
    idle_watch(30, "after_done");
    check("err_sticky_after_done", 64'(err_o), 64'b010);

    // Abort beats start in IDLE
    @(negedge clk);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    check("abort_beats_start", 64'(busy_o), 0);

    // Run 2: start clears err, abort during DRAIN of n=5 holds err
    push_run();
    pulse_start();
    check("run2_busy", 64'(busy_o), 1);
    check("err_cleared_on_start", 64'(err_o), 0);
    inject_overflow("run2");
    for (int w = 0; w < 5; w++) wait_write();
    repeat (16) @(negedge clk);
    check("busy_before_abort", 64'(busy_o), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_busy", 64'(busy_o), 0);
    check("abort_rd_en", 64'(rd_en_o), 0);
    check("abort_dsp_ce", 64'(dsp_ce_o), 0);
    check("abort_err_held", 64'(err_o), 64'b010);
    idle_watch(40, "after_abort");

    // Run 3: restart after abort begins again at n=0
    push_run();
    pulse_start();
    check("run3_busy", 64'(busy_o), 1);
    wait_write();
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("run3_abort_busy", 64'(busy_o), 0);
    sb.delete();

    // Reset together with start, then reset mid-ISSUE
    @(negedge clk);
    rst_i   = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    rst_i   = 1'b0;
    start_i = 1'b0;
    check("rst_start_busy", 64'(busy_o), 0);
    repeat (3) @(negedge clk);
    check("rst_start_idle", 64'(busy_o), 0);
    pulse_start();
    check("run4_busy", 64'(busy_o), 1);
    inject_overflow("run4");
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("midrst_busy", 64'(busy_o), 0);
    check("midrst_rd_en", 64'(rd_en_o), 0);
    check("midrst_h_addr", 64'(h_addr_o), 0);
    check("midrst_x_addr", 64'(x_addr_o), 0);
    check("midrst_dsp_ce", 64'(dsp_ce_o), 0);
    check("midrst_fpop", 64'(fpopmode_bit_o), 0);
    check("midrst_y_addr", 64'(y_addr_o), 0);
    check("midrst_y_data", 64'(y_data_o), 0);
    check("midrst_err", 64'(err_o), 0);
    idle_watch(30, "after_midrst");
    check("midrst_idle", 64'(busy_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Run-time controller for the single-DSP58 floating-point FIR datapath.
- Issues coefficient and sample addresses to the H/X memories and drives the DSP58 clock-enable and accumulate opmode bit.
- Captures each finished output sample into a result-buffer write port.
- Replaces the free-running test counter with a start/busy/done handshake, abort, and sticky exception reporting.

Parameters:
- H_ADDR_WIDTH, 4, coefficient address width; FILTER_LENGTH L = 1<<H_ADDR_WIDTH = 16 taps.
- X_ADDR_WIDTH, 6, sample address width; X_DEPTH = 1<<X_ADDR_WIDTH = 64.
- NUM_OUT, X_DEPTH-L+1 = 49, number of output samples per run.
- DATA_WIDTH, 32, IEEE-754 single-precision word width.
- MEM_LAT, 1, memory read latency in cycles (address to data).
- DSP_LAT, 4, DSP58 latency in cycles (input to y valid, including accumulate).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse; sampled only in IDLE.
- abort_i  in  1  returns the block to IDLE next cycle; beats start_i.
- busy_o  out  1  high from the cycle after an accepted start until done_o or abort.
- done_o  out  1  one-cycle pulse after the last result is written.
- rd_en_o  out  1  memory read enable.
- h_addr_o  out  H_ADDR_WIDTH  coefficient address k.
- x_addr_o  out  X_ADDR_WIDTH  sample address n+k.
- dsp_ce_o  out  1  DSP58 input-stage enable; equals rd_en_o delayed MEM_LAT.
- fpopmode_bit_o  out  1  0 = multiply only (tap 0, clears the accumulator); 1 = multiply-accumulate.
- y_i  in  DATA_WIDTH  DSP58 output.
- invalid_i, overflow_i, underflow_i  in  1 each  DSP58 exception flags.
- y_we_o  out  1  result-buffer write enable.
- y_addr_o  out  X_ADDR_WIDTH  output index n.
- y_data_o  out  DATA_WIDTH  registered copy of y_i at capture.
- err_o  out  3  sticky {invalid, overflow, underflow}.

Behaviour:
- Reset values: all outputs 0; state IDLE; n=0; k=0; flag pipeline flushed.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start_i && !abort_i, go to ISSUE, set n=0, k=0, clear err_o.
- ISSUE, one tap per cycle:
  - rd_en_o=1, h_addr_o=k, x_addr_o=n+k (no wrap; max 48+15=63).
  - Tag the tap with first=(k==0) and last=(k==L-1).
  - k increments; after k=L-1, go to DRAIN.
- Tag pipeline: tags travel a shift register MEM_LAT+DSP_LAT deep.
  - At depth MEM_LAT: dsp_ce_o=valid, fpopmode_bit_o = valid && !first.
  - At full depth with the last tag: y_we_o=1, y_addr_o=n, and y_data_o<=y_i registered one cycle later, with y_we_o delayed to match.
  - For every valid tag at full depth, err_o |= exception flags. Flags are ignored when no valid tag is at full depth.
- DRAIN: wait until the last-tap tag retires.
  - If n==NUM_OUT-1, go to DONE.
  - Otherwise increment n, set k=0, and return to ISSUE.
  - Outputs never overlap, because the accumulator is shared.
- Period per output: L+MEM_LAT+DSP_LAT = 21 cycles; write-enable spacing is exactly 21.
- DONE: done_o=1 for one cycle, busy_o=0, then IDLE.
- start_i while busy: ignored.
- abort_i in any state: next cycle IDLE, tags flushed, no further y_we_o, no done_o; err_o is held.
- rst_i mid-run: same as abort, and also clears err_o.

Decomposition:
- Package fir_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - the tag struct {valid, first, last};
  - derived constants L, NUM_OUT, PIPE_DEPTH = MEM_LAT+DSP_LAT.
- Sub-module fir_tag_pipe: parameterised-depth shift register of tags with synchronous flush, exposing taps at depth MEM_LAT and at full depth.

Test Plan:
- Reset then a single start_i pulse:
  - busy_o rises next cycle.
  - h_addr_o steps 0..15 while x_addr_o steps 0..15.
  - fpopmode_bit_o is 0 for exactly one cycle, at tap 0 plus MEM_LAT.
- Full run with h[k]=1.0 and x[i]=i:
  - 49 y_we_o pulses, 21 cycles apart.
  - y_addr_o runs 0..48, and y_data_o for n equals 16n+120.
  - done_o fires once, 1 cycle after the last write.
- start_i pulsed while busy: the run is unaffected and the total write count is still 49.
- abort_i asserted during DRAIN of n=5:
  - IDLE next cycle, no write for n=5, no done_o.
  - A new start restarts at n=0.
- overflow_i injected while a valid tag is at full depth: err_o=3'b010 stays set after done_o; the next start clears it.
- rst_i and start_i asserted together, then rst_i pulsed mid-ISSUE: all outputs 0 next cycle, and FSM is in IDLE.
